// File: rtl/riscv_trace_retire_buffer.sv
// Retire-record capture buffer feeding the instruction tracer: classifies each
// retired instruction, sequences it and queues it behind a valid/ready sink port.
module riscv_trace_retire_buffer #(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic                       flush_i,
  input  logic                       clear_ovf_i,
  input  logic                       retire_valid_i,
  input  logic [31:0]                retire_pc_i,
  input  logic [31:0]                retire_instr_i,
  input  logic                       retire_compressed_i,
  input  logic                       retire_rd_we_i,
  input  logic [5:0]                 retire_rd_addr_i,
  input  logic [31:0]                retire_rd_wdata_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [31:0]                trace_pc_o,
  output logic [31:0]                trace_instr_o,
  output logic [31:0]                trace_rd_wdata_o,
  output logic                       trace_compressed_o,
  output logic                       trace_rd_we_o,
  output logic [5:0]                 trace_rd_addr_o,
  output logic [3:0]                 trace_class_o,
  output logic [31:0]                trace_seq_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_WIDTH-1:0]       drop_cnt_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
  localparam logic [6:0] OPC_FENCE    = 7'h0f;
  localparam logic [6:0] OPC_OPIMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_STORE_FP = 7'h27;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_FMADD    = 7'h43;
  localparam logic [6:0] OPC_FMSUB    = 7'h47;
  localparam logic [6:0] OPC_FNMSUB   = 7'h4b;
  localparam logic [6:0] OPC_FNMADD   = 7'h4f;
  localparam logic [6:0] OPC_OP_FP    = 7'h53;
  localparam logic [6:0] OPC_PULP_OP  = 7'h5b;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_DIFT     = 7'h6b;
  localparam logic [6:0] OPC_JAL      = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        compressed;
    logic        rd_we;
    logic [5:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [3:0]  cls;
    logic [31:0] seq;
  } entry_t;

  function automatic logic [3:0] classify(input logic [31:0] instr);
    logic [3:0] cls;
    unique case (instr[6:0])
      OPC_OPIMM, OPC_LUI, OPC_AUIPC:            cls = 4'd1;
      OPC_OP:      cls = (instr[31:25] == 7'b0000001) ? 4'd8 : 4'd1;
      OPC_BRANCH:                               cls = 4'd2;
      OPC_JAL:                                  cls = 4'd3;
      OPC_JALR:    cls = (instr[14:12] == 3'b000) ? 4'd3 : 4'd0;
      OPC_LOAD, OPC_LOAD_FP:                    cls = 4'd4;
      OPC_STORE, OPC_STORE_FP:                  cls = 4'd5;
      OPC_SYSTEM:  cls = (instr[14:12] != 3'b000) ? 4'd6 : 4'd7;
      OPC_FENCE:                                cls = 4'd7;
      OPC_PULP_OP:                              cls = 4'd8;
      OPC_OP_FP, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: cls = 4'd9;
      OPC_DIFT:                                 cls = 4'd10;
      default:                                  cls = 4'd0;
    endcase
    return cls;
  endfunction

  entry_t               mem_r [DEPTH];
  logic [AW:0]          wr_ptr_r, rd_ptr_r;
  logic [31:0]          seq_r;
  logic [CNT_WIDTH-1:0] drop_cnt_r;
  logic                 overflow_r;

  logic [AW:0] count_s;
  logic        push_req_s, pop_s, accept_s, drop_s, full_s;
  entry_t      new_entry_s, head_s;

  // Handshake decode; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    count_s     = wr_ptr_r - rd_ptr_r;
    full_s      = (count_s == FULL_CNT);
    push_req_s  = retire_valid_i && enable_i;
    pop_s       = (count_s != '0) && trace_ready_i;
    accept_s    = push_req_s && !flush_i && (!full_s || pop_s);
    drop_s      = push_req_s && !accept_s;
    new_entry_s = '{pc: retire_pc_i, instr: retire_instr_i,
                    compressed: retire_compressed_i, rd_we: retire_rd_we_i,
                    rd_addr: retire_rd_addr_i, rd_wdata: retire_rd_wdata_i,
                    cls: classify(retire_instr_i), seq: seq_r};
    head_s      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Read/write pointers with wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (accept_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_s)    rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Entry storage, cleared on reset so the head fields read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (accept_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= new_entry_s;
    end
  end

  // Sequence counter advances on every enabled retire, stored or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_r <= 32'd0;
    end else if (push_req_s) begin
      seq_r <= seq_r + 32'd1;
    end
  end

  // Saturating drop counter and sticky overflow; a drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= '0;
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (clear_ovf_i)         drop_cnt_r <= CNT_WIDTH'(1);
      else if (drop_cnt_r != '1) drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
    end else if (clear_ovf_i) begin
      drop_cnt_r <= '0;
      overflow_r <= 1'b0;
    end
  end

  assign trace_valid_o      = (count_s != '0);
  assign trace_pc_o         = head_s.pc;
  assign trace_instr_o      = head_s.instr;
  assign trace_rd_wdata_o   = head_s.rd_wdata;
  assign trace_compressed_o = head_s.compressed;
  assign trace_rd_we_o      = head_s.rd_we;
  assign trace_rd_addr_o    = head_s.rd_addr;
  assign trace_class_o      = head_s.cls;
  assign trace_seq_o        = head_s.seq;
  assign count_o            = count_s;
  assign drop_cnt_o         = drop_cnt_r;
  assign overflow_o         = overflow_r;

endmodule

// File: tb/tb_riscv_trace_retire_buffer.sv
// Bench for riscv_trace_retire_buffer: classification table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_riscv_trace_retire_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0, flush_i = 1'b0, clear_ovf_i = 1'b0;
  logic        retire_valid_i = 1'b0;
  logic [31:0] retire_pc_i = 32'd0, retire_instr_i = 32'd0, retire_rd_wdata_i = 32'd0;
  logic        retire_compressed_i = 1'b0, retire_rd_we_i = 1'b0;
  logic [5:0]  retire_rd_addr_i = 6'd0;
  logic        trace_ready_i = 1'b0;
  logic        trace_valid_o, trace_compressed_o, trace_rd_we_o, overflow_o;
  logic [31:0] trace_pc_o, trace_instr_o, trace_rd_wdata_o, trace_seq_o;
  logic [5:0]  trace_rd_addr_o;
  logic [3:0]  trace_class_o;
  logic [3:0]  count_o;
  logic [CW-1:0] drop_cnt_o;

  riscv_trace_retire_buffer #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .flush_i(flush_i),
    .clear_ovf_i(clear_ovf_i), .retire_valid_i(retire_valid_i),
    .retire_pc_i(retire_pc_i), .retire_instr_i(retire_instr_i),
    .retire_compressed_i(retire_compressed_i), .retire_rd_we_i(retire_rd_we_i),
    .retire_rd_addr_i(retire_rd_addr_i), .retire_rd_wdata_i(retire_rd_wdata_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
    .trace_rd_wdata_o(trace_rd_wdata_o), .trace_compressed_o(trace_compressed_o),
    .trace_rd_we_o(trace_rd_we_o), .trace_rd_addr_o(trace_rd_addr_o),
    .trace_class_o(trace_class_o), .trace_seq_o(trace_seq_o),
    .count_o(count_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, wdata, seq;
    logic        comp, we;
    logic [5:0]  rd;
    logic [3:0]  cls;
  } rec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  exp_class;
  } vec_t;

  rec_t        q[$];
  logic [31:0] m_seq;
  int          m_drops;
  logic        m_ovf;
  int          errors = 0;
  int          checks = 0;

  // Spec classification written directly from the opcode table.
  function automatic logic [3:0] ref_class(logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    if (op == 7'h13 || op == 7'h37 || op == 7'h17) return 4'd1;
    if (op == 7'h33) return (w[31:25] == 7'b0000001) ? 4'd8 : 4'd1;
    if (op == 7'h63) return 4'd2;
    if (op == 7'h6f || (op == 7'h67 && f3 == 3'd0)) return 4'd3;
    if (op == 7'h03 || op == 7'h07) return 4'd4;
    if (op == 7'h23 || op == 7'h27) return 4'd5;
    if (op == 7'h73) return (f3 != 3'd0) ? 4'd6 : 4'd7;
    if (op == 7'h0f) return 4'd7;
    if (op == 7'h5b) return 4'd8;
    if (op == 7'h53 || op == 7'h43 || op == 7'h47 || op == 7'h4b || op == 7'h4f) return 4'd9;
    if (op == 7'h6b) return 4'd10;
    return 4'd0;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit push_req, pop, accept, drop;
    rec_t r;
    push_req = retire_valid_i && enable_i;
    pop      = (q.size() != 0) && trace_ready_i;
    accept   = 1'b0;
    if (flush_i) begin
      q.delete();
    end else begin
      accept = push_req && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (accept) begin
        r.pc = retire_pc_i; r.instr = retire_instr_i; r.wdata = retire_rd_wdata_i;
        r.comp = retire_compressed_i; r.we = retire_rd_we_i; r.rd = retire_rd_addr_i;
        r.cls = ref_class(retire_instr_i); r.seq = m_seq;
        q.push_back(r);
      end
    end
    drop = push_req && !accept;
    if (drop) begin
      m_drops = clear_ovf_i ? 1 : ((m_drops < SAT) ? m_drops + 1 : SAT);
      m_ovf   = 1'b1;
    end else if (clear_ovf_i) begin
      m_drops = 0;
      m_ovf   = 1'b0;
    end
    if (push_req) m_seq = m_seq + 32'd1;
  endtask

  task automatic compare_model();
    check("valid", 160'(trace_valid_o), 160'(q.size() != 0));
    check("count", 160'(count_o), 160'(q.size()));
    check("drop_cnt", 160'(drop_cnt_o), 160'(m_drops));
    check("overflow", 160'(overflow_o), 160'(m_ovf));
    if (q.size() != 0)
      check("head", {trace_pc_o, trace_instr_o, trace_rd_wdata_o, trace_seq_o,
                     trace_comp_we_rd_cls()},
                    {q[0].pc, q[0].instr, q[0].wdata, q[0].seq,
                     q[0].comp, q[0].we, q[0].rd, q[0].cls});
  endtask

  function automatic logic [11:0] trace_comp_we_rd_cls();
    return {trace_compressed_o, trace_rd_we_o, trace_rd_addr_o, trace_class_o};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic set_retire(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    retire_valid_i      = v;
    retire_instr_i      = instr;
    retire_pc_i         = pc;
    retire_compressed_i = 1'($urandom_range(0, 1));
    retire_rd_we_i      = 1'($urandom_range(0, 1));
    retire_rd_addr_i    = 6'($urandom);
    retire_rd_wdata_i   = $urandom;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs",
          {trace_valid_o, trace_pc_o, trace_instr_o, trace_rd_wdata_o, trace_seq_o,
           trace_comp_we_rd_cls(), count_o, drop_cnt_o, overflow_o}, 160'd0);
    q.delete();
    m_seq = 32'd0; m_drops = 0; m_ovf = 1'b0;
    retire_valid_i = 1'b0; flush_i = 1'b0; clear_ovf_i = 1'b0;
    enable_i = 1'b1; trace_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{32'h00208463, 32'h100, 4'd2};   // BEQ
    tbl[1]  = '{32'h008000ef, 32'h104, 4'd3};   // JAL
    tbl[2]  = '{32'h0000a103, 32'h108, 4'd4};   // LW
    tbl[3]  = '{32'h0020a023, 32'h10c, 4'd5};   // SW
    tbl[4]  = '{32'h34029073, 32'h110, 4'd6};   // CSRRW
    tbl[5]  = '{32'h30200073, 32'h114, 4'd7};   // MRET
    tbl[6]  = '{32'h022081b3, 32'h118, 4'd8};   // MUL
    tbl[7]  = '{32'h003100d3, 32'h11c, 4'd9};   // FADD.S
    tbl[8]  = '{32'h0020806b, 32'h120, 4'd10};  // DIFT tag set
    tbl[9]  = '{32'h000010b7, 32'h124, 4'd1};   // LUI
    tbl[10] = '{32'h0020e1b3, 32'h128, 4'd1};   // OR
    tbl[11] = '{32'h0000000f, 32'h12c, 4'd7};   // FENCE
    tbl[12] = '{32'h00009067, 32'h130, 4'd0};   // JALR with funct3!=0
    tbl[13] = '{32'h0000005b, 32'h134, 4'd8};   // PULP_OP
    tbl[14] = '{32'h00002007, 32'h138, 4'd4};   // FLW
    tbl[15] = '{32'hffffffff, 32'h13c, 4'd0};   // illegal

    apply_reset();

    // Single ADDI with ready high
    trace_ready_i = 1'b1;
    set_retire(1'b1, 32'h00500093, 32'h80);
    cycle();
    check("addi_valid", 160'(trace_valid_o), 160'd1);
    check("addi_class", 160'(trace_class_o), 160'd1);
    check("addi_seq", 160'(trace_seq_o), 160'd0);
    check("addi_pc", 160'(trace_pc_o), 160'h80);
    set_retire(1'b0, 32'd0, 32'd0);
    cycle();
    check("addi_drained", 160'(trace_valid_o), 160'd0);

    // Classification table, back-to-back with ready high
    apply_reset();
    trace_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_retire(1'b1, tbl[i].instr, tbl[i].pc);
      cycle();
      check($sformatf("class[%0d]", i), 160'(trace_class_o), 160'(tbl[i].exp_class));
      check($sformatf("seq[%0d]", i), 160'(trace_seq_o), 160'(i));
    end
    set_retire(1'b0, 32'd0, 32'd0);
    cycle();

    // Overflow with backpressure, then drain
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      set_retire(1'b1, 32'h00100093, 32'(i * 4));
      cycle();
    end
    check("ovf_count", 160'(count_o), 160'd8);
    check("ovf_drops", 160'(drop_cnt_o), 160'd3);
    check("ovf_flag", 160'(overflow_o), 160'd1);
    set_retire(1'b0, 32'd0, 32'd0);
    trace_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_seq[%0d]", i), 160'(trace_seq_o), 160'(i));
      cycle();
    end
    set_retire(1'b1, 32'h00100093, 32'h200);
    cycle();
    check("post_drain_seq", 160'(trace_seq_o), 160'd11);

    // Full pass-through
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      set_retire(1'b1, 32'h00000013, 32'(i));
      cycle();
    end
    trace_ready_i = 1'b1;
    set_retire(1'b1, 32'h00000013, 32'h300);
    cycle();
    check("pass_count", 160'(count_o), 160'd8);
    check("pass_drops", 160'(drop_cnt_o), 160'd0);
    check("pass_head_seq", 160'(trace_seq_o), 160'd1);

    // Flush with a concurrent retire
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_retire(1'b1, 32'h00000013, 32'(i));
      cycle();
    end
    flush_i = 1'b1;
    set_retire(1'b1, 32'h00000013, 32'h400);
    cycle();
    check("flush_count", 160'(count_o), 160'd0);
    check("flush_valid", 160'(trace_valid_o), 160'd0);
    check("flush_drop", 160'(drop_cnt_o), 160'd1);
    flush_i = 1'b0;
    set_retire(1'b1, 32'h00000013, 32'h404);
    cycle();
    check("flush_next_seq", 160'(trace_seq_o), 160'd6);

    // Drop counter saturation, clear vs drop, async reset mid-burst
    apply_reset();
    for (int i = 0; i < 28; i++) begin
      set_retire(1'b1, 32'h00000013, 32'(i));
      cycle();
    end
    check("sat_drops", 160'(drop_cnt_o), 160'(SAT));
    clear_ovf_i = 1'b1;
    cycle();
    check("clear_drop_cnt", 160'(drop_cnt_o), 160'd1);
    check("clear_drop_ovf", 160'(overflow_o), 160'd1);
    set_retire(1'b0, 32'd0, 32'd0);
    cycle();
    check("clear_only", 160'({drop_cnt_o, overflow_o}), 160'd0);
    clear_ovf_i = 1'b0;
    set_retire(1'b1, 32'h00000013, 32'h500);
    cycle();
    cycle();
    apply_reset();

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      enable_i      = ($urandom_range(0, 7) != 0);
      flush_i       = ($urandom_range(0, 31) == 0);
      clear_ovf_i   = ($urandom_range(0, 15) == 0);
      trace_ready_i = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1)
        set_retire($urandom_range(0, 3) != 0, tbl[$urandom_range(0, 15)].instr, $urandom);
      else
        set_retire($urandom_range(0, 3) != 0, $urandom, $urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_trace_retire_buffer.md
Name: riscv_trace_retire_buffer

Overview:
Capture stage that sits directly upstream of the instruction tracer. It takes one retired-instruction record per cycle from the core's writeback/retire point and tags it with a coarse instruction class, decoded from the RV32IMF/PULP/DIFT opcode masks. Records are buffered in a small FIFO and presented to the tracer sink over a valid/ready handshake. Sink backpressure never stalls the core: overflow drops records and counts them.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, minimum 2.
CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
enable_i  in  1  capture enable; when 0, retires are ignored entirely (no seq increment, no drop)
flush_i  in  1  synchronous FIFO clear
clear_ovf_i  in  1  clears overflow_o and drop_cnt_o
retire_valid_i  in  1  one instruction retires this cycle
retire_pc_i  in  32  PC of retiring instruction
retire_instr_i  in  32  expanded 32-bit instruction word
retire_compressed_i  in  1  original encoding was RVC
retire_rd_we_i  in  1  register write performed
retire_rd_addr_i  in  6  destination register; bit 5 selects the FP file
retire_rd_wdata_i  in  32  written value
trace_valid_o  out  1  head record valid
trace_ready_i  in  1  sink accepts head record
trace_pc_o / trace_instr_o / trace_rd_wdata_o  out  32 each  head record fields
trace_compressed_o / trace_rd_we_o  out  1 each  head record fields
trace_rd_addr_o  out  6  head record field
trace_class_o  out  4  class code of head record
trace_seq_o  out  32  sequence number of head record
count_o  out  $clog2(DEPTH)+1  current occupancy
drop_cnt_o  out  CNT_WIDTH  dropped records, saturating
overflow_o  out  1  sticky: at least one drop since last clear

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following are 0 — FIFO pointers, count_o, trace_valid_o, every trace_* field, drop_cnt_o, overflow_o, and the seq counter.
- Classification (combinational on retire_instr_i, stored with the entry):
  - 0 OTHER/illegal.
  - 1 ALU: OPIMM, LUI, AUIPC, or OP with funct7 not equal to 0000001.
  - 2 BRANCH: any BRANCH funct3, including BEQIMM/BNEIMM.
  - 3 JUMP: JAL, or JALR with funct3=000.
  - 4 LOAD: LOAD and LOAD_FP opcodes.
  - 5 STORE: STORE and STORE_FP opcodes.
  - 6 CSR: SYSTEM with funct3 not equal to 000.
  - 7 SYSTEM: SYSTEM with funct3=000 (ECALL/EBREAK/xRET/WFI), and FENCE/FENCE.I.
  - 8 MULDIV: OP with funct7=0000001, and PULP_OP (OPCODE_PULP_OP).
  - 9 FP: OP_FP, FMADD, FMSUB, FNMSUB, FNMADD.
  - 10 DIFT: OPCODE_DIFT.
  - Codes 11-15 are reserved and never produced.
- Sequence number:
  - A 32-bit seq counter increments on every cycle with retire_valid_i && enable_i, whether the record is stored or dropped.
  - A stored entry carries the pre-increment value.
  - Wraps modulo 2^32.
- Push and pop:
  - push_req = retire_valid_i && enable_i.
  - pop = trace_valid_o && trace_ready_i.
  - Push is accepted if !full, or if full && pop in the same cycle (pass-through slot reuse).
- Drops:
  - A push_req that is not accepted is dropped: drop_cnt_o increments (saturates at all-ones) and overflow_o sets.
  - clear_ovf_i zeroes drop_cnt_o and overflow_o. If a drop occurs in the same cycle, the drop wins: drop_cnt_o=1, overflow_o=1.
- Latency:
  - A record pushed into an empty FIFO appears on trace_valid_o/trace_* in the next cycle. There is no combinational input-to-output path.
  - trace_* reflect the head entry while trace_valid_o=1. They are held stable until popped.
  - trace_valid_o = (count_o != 0).
- Simultaneous push and pop: count_o is unchanged and pointers advance independently. On an empty FIFO a push and a pop cannot both occur, since trace_valid_o=0.
- Pointers: wrap modulo DEPTH, with an extra wrap bit for full/empty.
- flush_i:
  - Next cycle: count_o=0 and trace_valid_o=0. seq is not reset.
  - A concurrent push_req still increments seq and is discarded as a drop (drop_cnt_o+1, overflow_o=1).
  - A concurrent pop has no further effect.
- enable_i deasserted mid-stream: buffered entries keep draining normally.

Test Plan:
- Reset, then a single retire of ADDI (instr 0x00500093, pc 0x80) with trace_ready_i=1 -> next cycle trace_valid_o=1, trace_class_o=1, trace_seq_o=0, trace_pc_o=0x80; following cycle trace_valid_o=0.
- Class sweep: retire BEQ, JAL, LW, SW, CSRRW, MRET, MUL (funct7=0000001), FADD.S, DIFT TAGSET in sequence -> trace_class_o = 2,3,4,5,6,7,8,9,10 in order, with seq 0..8.
- Backpressure overflow with DEPTH=8: trace_ready_i=0, 11 back-to-back retires -> count_o=8, drop_cnt_o=3, overflow_o=1. Then drain with ready=1 -> seq values 0..7 emitted. Next retire carries seq 11.
- Full pass-through: FIFO full, one retire while trace_ready_i=1 -> accepted, count_o stays 8, drop_cnt_o unchanged.
- flush_i asserted together with a retire while count_o=5 -> next cycle count_o=0, trace_valid_o=0, drop_cnt_o+1. The next stored record's seq is the previous value +1.
- Saturation with CNT_WIDTH=4: 20 drops -> drop_cnt_o=15. Then clear_ovf_i together with a drop -> drop_cnt_o=1, overflow_o=1. Asynchronous reset asserted mid-burst -> all outputs 0 immediately.
